// File: rtl/pll_reset_sequencer.sv
// Power-up sequencer: pulses the PLL reset, waits for a stable lock, then releases
// the SDRAM-controller reset and the system reset in order. Lock loss restarts the PLL.
module pll_reset_sequencer #(
  parameter int PLL_RST_CYCLES     = 16,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int STAGGER_CYCLES     = 8,
  parameter int RELOCK_TIMEOUT     = 65536,
  parameter int SYNC_STAGES        = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sdram_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       lock_lost,
  output logic [7:0] retry_count
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_P = max2(max2(PLL_RST_CYCLES, LOCK_STABLE_CYCLES),
                              max2(STAGGER_CYCLES, RELOCK_TIMEOUT));
  localparam int CNT_W = ($clog2(MAX_P) < 1) ? 1 : $clog2(MAX_P);

  localparam logic [CNT_W-1:0] PLL_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [CNT_W-1:0] RELOCK_LAST  = CNT_W'(RELOCK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic             locked_s;
  logic             retry_inc;
  logic             lost_next;
  logic [7:0]       retry_next;
  logic             pll_rst_next, sdram_rst_next, sys_rst_next, ready_next;

  // pll_locked comes from the PLL's own clock domain; only the last stage is used.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_reg <= '0;
    else     sync_reg <= {sync_reg[SYNC_STAGES-2:0], pll_locked};
  end
  assign locked_s = sync_reg[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= RESET_PLL;
      cnt_reg     <= '0;
      pll_rst     <= 1'b1;
      sdram_rst   <= 1'b1;
      sys_rst     <= 1'b1;
      ready       <= 1'b0;
      lock_lost   <= 1'b0;
      retry_count <= 8'd0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      pll_rst     <= pll_rst_next;
      sdram_rst   <= sdram_rst_next;
      sys_rst     <= sys_rst_next;
      ready       <= ready_next;
      lock_lost   <= lost_next;
      retry_count <= retry_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + CNT_W'(1);
    retry_inc  = 1'b0;
    lost_next  = 1'b0;
    case (state_reg)
      RESET_PLL: if (cnt_reg == PLL_LAST) state_next = WAIT_LOCK;
      WAIT_LOCK: begin
        if (locked_s) state_next = STABLE;
        else if (cnt_reg == RELOCK_LAST) begin
          state_next = RESET_PLL;
          retry_inc  = 1'b1;
        end
      end
      STABLE: begin
        if (!locked_s) state_next = WAIT_LOCK;
        else if (cnt_reg == STABLE_LAST) state_next = RELEASE;
      end
      RELEASE: begin
        if (!locked_s) begin
          state_next = RESET_PLL;
          retry_inc  = 1'b1;
          lost_next  = 1'b1;
        end else if (cnt_reg == STAGGER_LAST) state_next = RUN;
      end
      RUN: begin
        cnt_next = cnt_reg;
        if (!locked_s) begin
          state_next = RESET_PLL;
          retry_inc  = 1'b1;
          lost_next  = 1'b1;
        end
      end
      default: state_next = RESET_PLL;
    endcase
    if (state_next != state_reg) cnt_next = '0;
    retry_next = (retry_inc && retry_count != 8'hFF) ? retry_count + 8'd1 : retry_count;
  end

  // Decoding the next state lets every output change on the same edge as the state.
  always_comb begin
    pll_rst_next   = (state_next == RESET_PLL);
    sdram_rst_next = !(state_next inside {RELEASE, RUN});
    sys_rst_next   = (state_next != RUN);
    ready_next     = (state_next == RUN);
  end

endmodule
